// File: rtl/output_fifo_ctrl_if.sv
// CPU-side write port and output_port drive bundle
// for the paced output FIFO.
interface output_fifo_ctrl_if #(
    parameter int OutSize = 2,
    parameter int Depth   = 4
);
    localparam int CW = $clog2(Depth) + 1;

    logic               WR;
    logic [OutSize-1:0] WR_DATA;
    logic               CLR_OVF;
    logic [OutSize-1:0] DATA;
    logic               Load;
    logic               FULL;
    logic               EMPTY;
    logic [CW-1:0]      COUNT;
    logic               OVF;

    modport master (
        output WR, WR_DATA, CLR_OVF,
        input  DATA, Load, FULL, EMPTY, COUNT, OVF
    );

    modport slave (
        input  WR, WR_DATA, CLR_OVF,
        output DATA, Load, FULL, EMPTY, COUNT, OVF
    );
endinterface

// File: rtl/output_fifo_ctrl.sv
// Buffered, rate-limited driver for output_port:
// queues CPU writes and replays them as paced Load pulses.
module output_fifo_ctrl #(
    parameter int OutSize    = 2,
    parameter int Depth      = 4,
    parameter int HoldCycles = 3
) (
    input  logic CLK,
    input  logic RST,
    output_fifo_ctrl_if.slave bus
);
    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;
    localparam int HW = $clog2(HoldCycles + 1);
    localparam logic [HW-1:0] HINIT =
        HW'(HoldCycles > 1 ? HoldCycles - 2 : 0);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } state_t;

    logic [OutSize-1:0] mem [Depth];
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic [CW-1:0]      count;
    logic               ovf_q;
    state_t             state;
    logic [HW-1:0]      hcnt;
    logic [OutSize-1:0] data_q;
    logic               load_q;

    logic full;
    logic empty;
    logic wr_ok;
    logic ready;
    logic pop;

    assign full  = (count == CW'(Depth));
    assign empty = (count == '0);
    assign wr_ok = bus.WR && !full;

    // LOAD (single-cycle hold) and an expired HOLD act as IDLE
    // so that loads land exactly HoldCycles apart.
    assign ready = (state == IDLE)
                || (state == LOAD && HoldCycles == 1)
                || (state == HOLD && hcnt == '0);
    assign pop   = ready && !empty;

    always_ff @(posedge CLK) begin
        if (wr_ok) mem[wptr] <= bus.WR_DATA;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + PW'(1);
            if (pop)   rptr <= rptr + PW'(1);
            unique case ({wr_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (bus.WR && full) ovf_q <= 1'b1;
            else if (bus.CLR_OVF) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            hcnt   <= '0;
            data_q <= '0;
            load_q <= 1'b0;
        end else if (pop) begin
            state  <= LOAD;
            data_q <= mem[rptr];
            load_q <= 1'b1;
        end else begin
            load_q <= 1'b0;
            if (ready) begin
                state <= IDLE;
            end else if (state == LOAD) begin
                state <= HOLD;
                hcnt  <= HINIT;
            end else begin
                hcnt <= hcnt - HW'(1);
            end
        end
    end

    assign bus.DATA  = data_q;
    assign bus.Load  = load_q;
    assign bus.FULL  = full;
    assign bus.EMPTY = empty;
    assign bus.COUNT = count;
    assign bus.OVF   = ovf_q;
endmodule
